button_conditioner: RTL and testbench

//  Conditions the four raw maze-game push-buttons (0=up, 1=down, 2=left, 3=right) into clean controls.

---
 rtl/button_conditioner_if.sv | 13 +
 rtl/button_conditioner.sv | 140 ++++++++++++++
 tb/tb_button_conditioner.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Groups the raw button levels and the three conditioned control vectors.
// The master drives btn_raw and receives the outputs; the slave is the conditioner.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] DPBs;
    logic [N_BTN-1:0] SCENs;
    logic [N_BTN-1:0] MCENs;

    modport master (output btn_raw, input DPBs, input SCENs, input MCENs);
    modport slave  (input btn_raw, output DPBs, output SCENs, output MCENs);
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debounce FSM, press pulse and auto-repeat pulse; all outputs registered.
// Press/release latency SYNC_STAGES+DEBOUNCE_CYCLES edges; no backpressure, pulses are fire-and-forget.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btns
);
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam bit RPT_EN  = (REPEAT_DELAY != 0);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_TOP      = RPT_W'(RPT_MAX);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    logic [N_BTN-1:0] dpb_w;
    logic [N_BTN-1:0] scen_w;
    logic [N_BTN-1:0] mcen_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [1:0]             state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [RPT_W-1:0]       rpt_q, rpt_d;
        logic                   phase_q, phase_d;
        logic                   dpb_q, dpb_d;
        logic                   scen_q, scen_d;
        logic                   mcen_q, mcen_d;
        logic                   btn_s;

        assign btn_s = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], btns.btn_raw[i]};
            state_d = state_q;
            cnt_d   = cnt_q;
            rpt_d   = rpt_q;
            phase_d = phase_q;
            dpb_d   = dpb_q;
            scen_d  = 1'b0;
            mcen_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    dpb_d = 1'b0;
                    if (btn_s) begin
                        state_d = WAIT_PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_PRESS: begin
                    if (!btn_s) begin
                        state_d = IDLE;
                    end else if (cnt_q < CNT_DONE) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = HELD;
                        dpb_d   = 1'b1;
                        scen_d  = 1'b1;
                        mcen_d  = 1'b1;
                        rpt_d   = '0;
                        phase_d = 1'b0;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_d = WAIT_RELEASE;
                        cnt_d   = CNT_ONE;
                    end else if (RPT_EN) begin
                        // rpt counts held edges since the last MCEN; phase selects delay vs period
                        if (!phase_q && rpt_q == RPT_DLY_LAST) begin
                            mcen_d  = 1'b1;
                            rpt_d   = '0;
                            phase_d = 1'b1;
                        end else if (phase_q && rpt_q == RPT_PER_LAST) begin
                            mcen_d = 1'b1;
                            rpt_d  = '0;
                        end else if (rpt_q != RPT_TOP) begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (btn_s) begin
                        state_d = HELD;
                    end else if (cnt_q < CNT_DONE) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        dpb_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q  <= '0;
                state_q <= IDLE;
                cnt_q   <= '0;
                rpt_q   <= '0;
                phase_q <= 1'b0;
                dpb_q   <= 1'b0;
                scen_q  <= 1'b0;
                mcen_q  <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rpt_q   <= rpt_d;
                phase_q <= phase_d;
                dpb_q   <= dpb_d;
                scen_q  <= scen_d;
                mcen_q  <= mcen_d;
            end
        end

        assign dpb_w[i]  = dpb_q;
        assign scen_w[i] = scen_q;
        assign mcen_w[i] = mcen_q;
    end

    assign btns.DPBs  = dpb_w;
    assign btns.SCENs = scen_w;
    assign btns.MCENs = mcen_w;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (auto-repeat on / off) share one stimulus,
// checked every cycle against a run-length model plus literal pulse-position masks.
module tb_button_conditioner;
    localparam int DEB = 4;
    localparam int PER = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;

    int tests = 0;
    int fails = 0;

    button_conditioner_if #(.N_BTN(4)) if_a ();
    button_conditioner_if #(.N_BTN(4)) if_b ();
    assign if_a.btn_raw = btn;
    assign if_b.btn_raw = btn;

    button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
                         .REPEAT_DELAY(20), .REPEAT_PERIOD(PER))
        dut_a (.clk(clk), .reset(reset), .btns(if_a));
    button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
                         .REPEAT_DELAY(0), .REPEAT_PERIOD(PER))
        dut_b (.clk(clk), .reset(reset), .btns(if_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    // Model: btn_s is btn delayed two edges; a press is D+1 consecutive high samples,
    // a release D+1 consecutive low samples; repeats count edges high after a high edge.
    bit [1:0]   m_sq   [2][4];
    int         m_ones [2][4];
    int         m_zeros[2][4];
    int         m_k    [2][4];
    bit         m_prev [2][4];
    bit         m_dpb  [2][4];
    logic [3:0] e_dpb[2], e_sc[2], e_mc[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++) begin
                bit s;
                int dl;
                dl = (i == 0) ? 20 : 0;
                e_sc[i][b] = 1'b0;
                e_mc[i][b] = 1'b0;
                if (reset) begin
                    m_sq[i][b]    = 2'b00;
                    m_ones[i][b]  = 0;
                    m_zeros[i][b] = 0;
                    m_k[i][b]     = 0;
                    m_prev[i][b]  = 1'b0;
                    m_dpb[i][b]   = 1'b0;
                end else begin
                    s = m_sq[i][b][1];
                    m_sq[i][b] = {m_sq[i][b][0], btn[b]};
                    m_ones[i][b]  = s ? ((m_ones[i][b] < 1000) ? m_ones[i][b] + 1 : 1000) : 0;
                    m_zeros[i][b] = s ? 0 : ((m_zeros[i][b] < 1000) ? m_zeros[i][b] + 1 : 1000);
                    if (!m_dpb[i][b]) begin
                        if (m_ones[i][b] >= DEB + 1) begin
                            m_dpb[i][b] = 1'b1;
                            m_k[i][b]   = 0;
                            e_sc[i][b]  = 1'b1;
                            e_mc[i][b]  = 1'b1;
                        end
                    end else if (m_zeros[i][b] >= DEB + 1) begin
                        m_dpb[i][b] = 1'b0;
                    end else if (s && m_prev[i][b]) begin
                        m_k[i][b]++;
                        if (dl > 0 && (m_k[i][b] == dl ||
                                       (m_k[i][b] > dl && (m_k[i][b] - dl) % PER == 0)))
                            e_mc[i][b] = 1'b1;
                    end
                    m_prev[i][b] = s;
                end
                e_dpb[i][b] = m_dpb[i][b];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cmp_a_dpb",  {60'd0, if_a.DPBs},  {60'd0, e_dpb[0]});
        chk("cmp_a_scen", {60'd0, if_a.SCENs}, {60'd0, e_sc[0]});
        chk("cmp_a_mcen", {60'd0, if_a.MCENs}, {60'd0, e_mc[0]});
        chk("cmp_b_dpb",  {60'd0, if_b.DPBs},  {60'd0, e_dpb[1]});
        chk("cmp_b_scen", {60'd0, if_b.SCENs}, {60'd0, e_sc[1]});
        chk("cmp_b_mcen", {60'd0, if_b.MCENs}, {60'd0, e_mc[1]});
    end

    // Raw button level seen at relative edge r of test t.
    function automatic logic [3:0] pat(input int t, input int r);
        case (t)
            1: return {3'b000, r < 36};
            2: return {2'b00, (r < 40) && (r >= 20 || r % 4 != 3), 1'b0};
            3: return {1'b0, r < 3, 2'b00};
            4: return {3'b000, (r < 41) && (r < 10 || r > 11)};
            5: return {r < 30, 3'b000};
            6: return {r < 40, r < 40, 2'b00};
            default: return 4'b0000;
        endcase
    endfunction

    logic [63:0] hs[2][4], hm[2][4], hd[2][4];

    task automatic run_test(input int t, input int n);
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 4; b++) begin
                hs[i][b] = '0; hm[i][b] = '0; hd[i][b] = '0;
            end
        @(negedge clk);
        btn = pat(t, 0);
        for (int r = 0; r < n; r++) begin
            @(posedge clk);
            #1;
            for (int b = 0; b < 4; b++) begin
                hs[0][b][r] = if_a.SCENs[b]; hm[0][b][r] = if_a.MCENs[b]; hd[0][b][r] = if_a.DPBs[b];
                hs[1][b][r] = if_b.SCENs[b]; hm[1][b][r] = if_b.MCENs[b]; hd[1][b][r] = if_b.DPBs[b];
            end
            if (t == 5 && r == 11) begin
                chk("t5_rst_outs_a", {52'd0, if_a.DPBs, if_a.SCENs, if_a.MCENs}, 64'd0);
                chk("t5_rst_outs_b", {52'd0, if_b.DPBs, if_b.SCENs, if_b.MCENs}, 64'd0);
            end
            @(negedge clk);
            btn   = pat(t, r + 1);
            reset = (t == 5 && r + 1 == 11);
        end
        repeat (15) @(negedge clk);
    endtask

    initial begin
        btn   = 4'b0000;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_outs", {52'd0, if_a.DPBs, if_a.SCENs, if_a.MCENs}, 64'd0);
        chk("reset_b_outs", {52'd0, if_b.DPBs, if_b.SCENs, if_b.MCENs}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_test(1, 50);
        chk("t1_scen0", hs[0][0], 64'd1 << 6);
        chk("t1_mcen0", hm[0][0], (64'd1 << 6) | (64'd1 << 26) | (64'd1 << 34));
        chk("t1_dpb0",  hd[0][0], bits(6, 41));

        run_test(2, 55);
        chk("t2_scen1", hs[0][1], 64'd1 << 26);
        chk("t2_mcen1_b", hm[1][1], 64'd1 << 26);

        run_test(3, 20);
        chk("t3_btn2_quiet", hs[0][2] | hm[0][2] | hd[0][2] | hs[1][2] | hm[1][2] | hd[1][2], 64'd0);

        run_test(4, 60);
        chk("t4_scen0", hs[0][0], 64'd1 << 6);
        chk("t4_mcen0", hm[0][0], (64'd1 << 6) | (64'd1 << 29) | (64'd1 << 37));
        chk("t4_dpb0",  hd[0][0], bits(6, 46));

        run_test(5, 30);
        chk("t5_scen3", hs[0][3], (64'd1 << 6) | (64'd1 << 18));
        chk("t5_dpb3",  hd[0][3], bits(6, 10) | bits(18, 29));

        run_test(6, 55);
        chk("t6_b_scen2", hs[1][2], 64'd1 << 6);
        chk("t6_b_scen3", hs[1][3], 64'd1 << 6);
        chk("t6_b_mcen2", hm[1][2], 64'd1 << 6);
        chk("t6_b_mcen3", hm[1][3], 64'd1 << 6);
        chk("t6_a_mcen2", hm[0][2], (64'd1 << 6) | (64'd1 << 26) | (64'd1 << 34));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
